vec_issue_seq: RTL and testbench

// Issue-side sequencer that drives vec_exec and retires its results. Accepts one decoded

---
 rtl/vec_pkg.sv | 30 +++
 rtl/vec_tail_mask.sv | 22 ++
 rtl/vec_issue_seq.sv | 150 +++++++++++++++
 tb/tb_vec_issue_seq.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared vector-unit constants: element-width codes, issue FSM encoding
// and register-file geometry used by the sequencer, vec_exec and the VRF.
package vec_pkg;

    localparam int VLEN_BITS  = 256;
    localparam int VLEN_BYTES = VLEN_BITS / 8;
    localparam int VRF_ADDR_W = 5;

    localparam logic [2:0] VSEW_8  = 3'd0;
    localparam logic [2:0] VSEW_16 = 3'd1;
    localparam logic [2:0] VSEW_32 = 3'd2;
    localparam logic [2:0] VSEW_64 = 3'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    typedef struct packed {
        logic [5:0]            funct6;
        logic [2:0]            vsew;
        logic [31:0]           vlen;
        logic [VRF_ADDR_W-1:0] vd;
    } vec_op_t;

    function automatic logic vsew_legal(input logic [2:0] vsew);
        return vsew <= VSEW_64;
    endfunction

endpackage

// File: rtl/vec_tail_mask.sv
// Byte-enable generator: bytes below vlen<<vsew are active, the rest
// stay undisturbed; saturates at the full register width.
module vec_tail_mask #(
    parameter int NBYTES = 32
) (
    input  logic [31:0]       vlen,
    input  logic [2:0]        vsew,
    output logic [NBYTES-1:0] be
);

    logic [37:0] nbytes;

    // 38 bits holds vlen scaled by the widest legal element without wrap
    always_comb begin
        nbytes = {6'b0, vlen} << vsew;
        be     = '0;
        for (int i = 0; i < NBYTES; i++) begin
            be[i] = nbytes > 38'(i);
        end
    end

endmodule

// File: rtl/vec_issue_seq.sv
// Vector issue sequencer: accepts a decoded op, reads the VRF, launches
// vec_exec, then writes the result back under a tail byte mask.
module vec_issue_seq
    import vec_pkg::*;
#(
    parameter int VLEN_BITS  = 256,
    parameter int VRF_RD_LAT = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [5:0]             issue_funct6,
    input  logic [2:0]             issue_vsew,
    input  logic [31:0]            issue_vlen,
    input  logic [4:0]             issue_vs1,
    input  logic [4:0]             issue_vs2,
    input  logic [4:0]             issue_vd,
    output logic                   vrf_rd_en,
    output logic [4:0]             vrf_rs1_addr,
    output logic [4:0]             vrf_rs2_addr,
    input  logic [VLEN_BITS-1:0]   vrf_rs1_data,
    input  logic [VLEN_BITS-1:0]   vrf_rs2_data,
    output logic                   exec_start,
    output logic [5:0]             exec_funct6,
    output logic [2:0]             exec_vsew,
    output logic [31:0]            exec_vlen,
    output logic [VLEN_BITS-1:0]   exec_operand_a,
    output logic [VLEN_BITS-1:0]   exec_operand_b,
    input  logic [VLEN_BITS-1:0]   exec_result,
    input  logic                   exec_done,
    output logic                   vrf_wr_en,
    output logic [4:0]             vrf_wr_addr,
    output logic [VLEN_BITS-1:0]   vrf_wr_data,
    output logic [VLEN_BITS/8-1:0] vrf_wr_be,
    output logic                   vec_stall,
    output logic                   vec_err
);

    localparam int NB = VLEN_BITS / 8;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]           state;
    vec_op_t              op_q;
    logic [1:0]           rd_cnt;
    logic [TW-1:0]        to_cnt;
    logic [VLEN_BITS-1:0] opa_q;
    logic [VLEN_BITS-1:0] opb_q;
    logic [VLEN_BITS-1:0] res_q;
    logic                 start_q;
    logic                 err_q;
    logic [NB-1:0]        mask_be;

    logic accept;
    logic legal;
    logic launch;

    assign accept = (state == ST_IDLE) && issue_valid;
    assign legal  = vsew_legal(issue_vsew);
    assign launch = accept && legal && (issue_vlen != 32'd0);

    vec_tail_mask #(
        .NBYTES(NB)
    ) u_tail_mask (
        .vlen(op_q.vlen),
        .vsew(op_q.vsew),
        .be  (mask_be)
    );

    assign issue_ready    = (state == ST_IDLE);
    assign vrf_rd_en      = launch;
    assign vrf_rs1_addr   = launch ? issue_vs1 : '0;
    assign vrf_rs2_addr   = launch ? issue_vs2 : '0;
    assign vec_stall      = (state != ST_IDLE) || launch;
    assign vec_err        = err_q;

    assign exec_start     = start_q;
    assign exec_funct6    = op_q.funct6;
    assign exec_vsew      = op_q.vsew;
    assign exec_vlen      = op_q.vlen;
    assign exec_operand_a = opa_q;
    assign exec_operand_b = opb_q;

    assign vrf_wr_en      = (state == ST_WB);
    assign vrf_wr_addr    = vrf_wr_en ? op_q.vd : '0;
    assign vrf_wr_data    = vrf_wr_en ? res_q : '0;
    assign vrf_wr_be      = vrf_wr_en ? mask_be : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            rd_cnt  <= '0;
            to_cnt  <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        err_q <= !legal;
                        if (launch) begin
                            op_q.funct6 <= issue_funct6;
                            op_q.vsew   <= issue_vsew;
                            op_q.vlen   <= issue_vlen;
                            op_q.vd     <= issue_vd;
                            rd_cnt      <= '0;
                            state       <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (rd_cnt == 2'(VRF_RD_LAT - 1)) begin
                        opa_q   <= vrf_rs2_data;
                        opb_q   <= vrf_rs1_data;
                        start_q <= 1'b1;
                        to_cnt  <= '0;
                        state   <= ST_EXEC;
                    end else begin
                        rd_cnt <= rd_cnt + 2'd1;
                    end
                end
                ST_EXEC: begin
                    // to_cnt==0 is the launch cycle; done is not trusted yet
                    if (exec_done && (to_cnt != '0)) begin
                        res_q <= exec_result;
                        state <= ST_WB;
                    end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_WB: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_issue_seq.sv
// Scoreboard bench for vec_issue_seq: random ops against a VRF/exec model,
// expected launches and writebacks queued at issue, checked by a monitor.
module tb_vec_issue_seq;

    localparam int LAT = 2;
    localparam int TO  = 64;
    localparam int VB  = 256;

    logic            clk;
    logic            reset;
    logic            issue_valid;
    logic            issue_ready;
    logic [5:0]      issue_funct6;
    logic [2:0]      issue_vsew;
    logic [31:0]     issue_vlen;
    logic [4:0]      issue_vs1;
    logic [4:0]      issue_vs2;
    logic [4:0]      issue_vd;
    logic            vrf_rd_en;
    logic [4:0]      vrf_rs1_addr;
    logic [4:0]      vrf_rs2_addr;
    logic [VB-1:0]   vrf_rs1_data;
    logic [VB-1:0]   vrf_rs2_data;
    logic            exec_start;
    logic [5:0]      exec_funct6;
    logic [2:0]      exec_vsew;
    logic [31:0]     exec_vlen;
    logic [VB-1:0]   exec_operand_a;
    logic [VB-1:0]   exec_operand_b;
    logic [VB-1:0]   exec_result;
    logic            exec_done;
    logic            vrf_wr_en;
    logic [4:0]      vrf_wr_addr;
    logic [VB-1:0]   vrf_wr_data;
    logic [VB/8-1:0] vrf_wr_be;
    logic            vec_stall;
    logic            vec_err;

    logic resp_done;
    logic stray_done;
    assign exec_done = resp_done | stray_done;

    vec_issue_seq #(
        .VLEN_BITS (VB),
        .VRF_RD_LAT(LAT),
        .TIMEOUT   (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_funct6  (issue_funct6),
        .issue_vsew    (issue_vsew),
        .issue_vlen    (issue_vlen),
        .issue_vs1     (issue_vs1),
        .issue_vs2     (issue_vs2),
        .issue_vd      (issue_vd),
        .vrf_rd_en     (vrf_rd_en),
        .vrf_rs1_addr  (vrf_rs1_addr),
        .vrf_rs2_addr  (vrf_rs2_addr),
        .vrf_rs1_data  (vrf_rs1_data),
        .vrf_rs2_data  (vrf_rs2_data),
        .exec_start    (exec_start),
        .exec_funct6   (exec_funct6),
        .exec_vsew     (exec_vsew),
        .exec_vlen     (exec_vlen),
        .exec_operand_a(exec_operand_a),
        .exec_operand_b(exec_operand_b),
        .exec_result   (exec_result),
        .exec_done     (exec_done),
        .vrf_wr_en     (vrf_wr_en),
        .vrf_wr_addr   (vrf_wr_addr),
        .vrf_wr_data   (vrf_wr_data),
        .vrf_wr_be     (vrf_wr_be),
        .vec_stall     (vec_stall),
        .vec_err       (vec_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register-file model with a LAT-deep read pipeline
    logic [VB-1:0] vrf [32];
    logic [VB-1:0] pd1 [LAT];
    logic [VB-1:0] pd2 [LAT];

    always @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < LAT; k++) begin
                pd1[k] <= '0;
                pd2[k] <= '0;
            end
        end else begin
            if (vrf_rd_en) begin
                pd1[0] <= vrf[vrf_rs1_addr];
                pd2[0] <= vrf[vrf_rs2_addr];
            end
            for (int k = 1; k < LAT; k++) begin
                pd1[k] <= pd1[k-1];
                pd2[k] <= pd2[k-1];
            end
        end
    end
    assign vrf_rs1_data = pd1[LAT-1];
    assign vrf_rs2_data = pd2[LAT-1];

    typedef struct {
        logic [5:0]  f;
        logic [2:0]  sew;
        logic [31:0] vlen;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic [4:0]  vd;
        int          dly;
        bit          glitch;
    } op_t;

    typedef struct {
        logic [5:0]    f;
        logic [2:0]    sew;
        logic [31:0]   vlen;
        logic [VB-1:0] a;
        logic [VB-1:0] b;
        logic [VB-1:0] res;
        int            dly;
        bit            glitch;
        int unsigned   acc;
    } start_t;

    typedef struct {
        logic [4:0]    addr;
        logic [31:0]   be;
        logic [VB-1:0] data;
    } wr_t;

    start_t exp_start_q[$];
    wr_t    exp_wr_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [VB-1:0] act,
                       input logic [VB-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    // Active bytes = elements * bytes-per-element, capped at the register
    function automatic logic [31:0] exp_be(input logic [31:0] vlen,
                                           input logic [2:0] sew);
        longint unsigned nb;
        nb = 64'(vlen) * (64'd1 << sew);
        if (nb >= 64'd32) return 32'hFFFF_FFFF;
        return 32'((64'd1 << nb) - 64'd1);
    endfunction

    function automatic logic [VB-1:0] rand_wide();
        logic [VB-1:0] w;
        for (int i = 0; i < VB / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  s;
        o.f   = 6'($urandom_range(0, 63));
        s     = $urandom_range(0, 9);
        o.sew = (s == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        s     = $urandom_range(0, 9);
        if (s == 0)      o.vlen = 32'd0;
        else if (s == 1) o.vlen = $urandom();
        else             o.vlen = 32'($urandom_range(1, 40));
        o.vs1    = 5'($urandom_range(0, 31));
        o.vs2    = 5'($urandom_range(0, 31));
        o.vd     = 5'($urandom_range(0, 31));
        o.dly    = $urandom_range(1, 8);
        o.glitch = ($urandom_range(0, 3) == 0);
        return o;
    endfunction

    function automatic op_t mk_op(input logic [2:0] sew, input logic [31:0] vlen,
                                  input logic [4:0] vs1, input logic [4:0] vs2,
                                  input logic [4:0] vd, input int dly);
        op_t o;
        o.f      = 6'd0;
        o.sew    = sew;
        o.vlen   = vlen;
        o.vs1    = vs1;
        o.vs2    = vs2;
        o.vd     = vd;
        o.dly    = dly;
        o.glitch = 1'b0;
        return o;
    endfunction

    task automatic issue(input op_t o, output int unsigned acc);
        bit     legal;
        bit     launch;
        int     n;
        start_t s;
        wr_t    w;
        legal  = (o.sew <= 3'd3);
        launch = legal && (o.vlen != 32'd0);
        @(posedge clk);
        #1;
        issue_funct6 = o.f;
        issue_vsew   = o.sew;
        issue_vlen   = o.vlen;
        issue_vs1    = o.vs1;
        issue_vs2    = o.vs2;
        issue_vd     = o.vd;
        issue_valid  = 1'b1;
        @(negedge clk);
        n = 0;
        while (!issue_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", issue_ready, 1);
        acc = cyc;
        chk("rd_en_accept", vrf_rd_en, launch);
        chk("stall_accept", vec_stall, launch);
        if (launch) begin
            chk("rs1_addr", vrf_rs1_addr, o.vs1);
            chk("rs2_addr", vrf_rs2_addr, o.vs2);
            s.f = o.f;  s.sew = o.sew;  s.vlen = o.vlen;
            s.a = vrf[o.vs2];  s.b = vrf[o.vs1];
            s.res = rand_wide();
            s.dly = o.dly;  s.glitch = o.glitch;  s.acc = acc;
            exp_start_q.push_back(s);
            if (o.dly > 0) begin
                w.addr = o.vd;
                w.be   = exp_be(o.vlen, o.sew);
                w.data = s.res;
                exp_wr_q.push_back(w);
            end
        end
        @(posedge clk);
        #1;
        issue_valid  = 1'b0;
        issue_funct6 = 6'($urandom());
        issue_vsew   = 3'($urandom());
        issue_vlen   = $urandom();
        issue_vd     = 5'($urandom());
        @(negedge clk);
        chk("err_after_accept", vec_err, !legal);
        chk("ready_after_accept", issue_ready, !launch);
    endtask

    // Monitor and vec_exec responder
    start_t      cur;
    bit          busy = 0;
    int          rem = 0;
    int unsigned done_cyc = 0;

    initial begin
        resp_done   = 1'b0;
        exec_result = '0;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (busy) begin
                rem--;
                if (rem == 0) begin
                    busy        = 0;
                    resp_done   = 1'b1;
                    exec_result = cur.res;
                    done_cyc    = cyc;
                    chk("hold_funct6", exec_funct6, cur.f);
                    chk("hold_vlen", exec_vlen, cur.vlen);
                    chk("hold_opa", exec_operand_a, cur.a);
                    chk("hold_opb", exec_operand_b, cur.b);
                    chk("stall_exec", vec_stall, 1);
                end
            end
            if (exec_start) begin
                chk("start_expected", exp_start_q.size() != 0, 1);
                if (exp_start_q.size() != 0) begin
                    cur = exp_start_q.pop_front();
                    chk("start_latency", cyc - cur.acc, LAT + 1);
                    chk("exec_funct6", exec_funct6, cur.f);
                    chk("exec_vsew", exec_vsew, cur.sew);
                    chk("exec_vlen", exec_vlen, cur.vlen);
                    chk("exec_opa", exec_operand_a, cur.a);
                    chk("exec_opb", exec_operand_b, cur.b);
                    if (cur.glitch) resp_done = 1'b1;
                    if (cur.dly > 0) begin
                        busy = 1;
                        rem  = cur.dly;
                    end
                end
            end
            if (vrf_wr_en) begin
                chk("wr_expected", exp_wr_q.size() != 0, 1);
                if (exp_wr_q.size() != 0) begin
                    wr_t w;
                    w = exp_wr_q.pop_front();
                    chk("wr_latency", cyc - done_cyc, 1);
                    chk("wr_addr", vrf_wr_addr, w.addr);
                    chk("wr_be", vrf_wr_be, w.be);
                    chk("wr_data", vrf_wr_data, w.data);
                end
            end
        end
    end

    initial begin
        int unsigned acc;
        int          n;
        reset        = 1'b0;
        issue_valid  = 1'b0;
        issue_funct6 = '0;
        issue_vsew   = '0;
        issue_vlen   = '0;
        issue_vs1    = '0;
        issue_vs2    = '0;
        issue_vd     = '0;
        stray_done   = 1'b0;
        for (int i = 0; i < 32; i++) vrf[i] = rand_wide();

        #2;
        chk("rst_ready", issue_ready, 1);
        chk("rst_stall", vec_stall, 0);
        chk("rst_err", vec_err, 0);
        chk("rst_rd_en", vrf_rd_en, 0);
        chk("rst_start", exec_start, 0);
        chk("rst_wr_en", vrf_wr_en, 0);
        chk("rst_opa", exec_operand_a, 0);
        chk("rst_vlen", exec_vlen, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        issue(mk_op(3'd2, 32'd8, 5'd1, 5'd2, 5'd3, 5), acc);
        issue(mk_op(3'd0, 32'd5, 5'd4, 5'd5, 5'd6, 2), acc);
        issue(mk_op(3'd3, 32'd9, 5'd7, 5'd8, 5'd9, 1), acc);
        issue(mk_op(3'd3, 32'hFFFF_FFFF, 5'd10, 5'd11, 5'd12, 3), acc);
        issue(mk_op(3'd1, 32'd0, 5'd1, 5'd1, 5'd1, 1), acc);
        issue(mk_op(3'd5, 32'd4, 5'd2, 5'd3, 5'd4, 1), acc);
        issue(mk_op(3'd1, 32'd3, 5'd13, 5'd14, 5'd15, 4), acc);

        // exec_done withheld: the op must abort with vec_err after TO cycles
        issue(mk_op(3'd2, 32'd4, 5'd16, 5'd17, 5'd18, -1), acc);
        n = 0;
        while (!issue_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", cyc - acc, LAT + 1 + TO);
        chk("timeout_err", vec_err, 1);
        issue(mk_op(3'd0, 32'd33, 5'd19, 5'd20, 5'd21, 2), acc);

        // asynchronous reset while in EXEC, then a stray done
        issue(mk_op(3'd2, 32'd8, 5'd22, 5'd23, 5'd24, -1), acc);
        repeat (LAT + 4) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_ready", issue_ready, 1);
        chk("async_rst_stall", vec_stall, 0);
        chk("async_rst_opa", exec_operand_a, 0);
        chk("async_rst_funct6", exec_funct6, 0);
        chk("async_rst_wr_en", vrf_wr_en, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 stray_done = 1'b1;
        @(posedge clk);
        #1 stray_done = 1'b0;
        @(negedge clk);
        chk("stray_done_ready", issue_ready, 1);
        chk("stray_done_stall", vec_stall, 0);

        for (int i = 0; i < 40; i++) issue(rand_op(), acc);

        n = 0;
        while ((exp_wr_q.size() != 0 || !issue_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_wr", exp_wr_q.size(), 0);
        chk("drain_start", exp_start_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
